// File: rtl/data_mem_pkg.sv
// Shared encodings for the two-requester data memory controller.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Requester bus (request + response) and byte-enabled memory port.
interface data_mem_req_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            size;
    logic                  uns;
    logic [31:0]           wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport master (output valid, we, addr, size, uns, wdata,
                    input  ready, resp_valid, resp_rdata, resp_err);
    modport slave  (input  valid, we, addr, size, uns, wdata,
                    output ready, resp_valid, resp_rdata, resp_err);
endinterface

interface data_mem_mem_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-3:0] addr;
    logic                  we;
    logic                  re;
    logic [3:0]            byte_sel;
    logic [31:0]           wdata;
    logic [31:0]           rdata;

    modport master (output addr, we, re, byte_sel, wdata, input rdata);
    modport slave  (input  addr, we, re, byte_sel, wdata, output rdata);
endinterface

// File: rtl/data_mem_align.sv
// Byte-lane selection, store replication, load extension and alignment check.
module data_mem_align
    import data_mem_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic        err_o,
    output logic [3:0]  byte_sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o
);
    logic [7:0]  lb;
    logic [15:0] lh;

    assign lb = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign lh = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        err_o      = 1'b0;
        byte_sel_o = 4'b0000;
        wdata_o    = wdata_i;
        load_o     = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                byte_sel_o = 4'b0001 << addr_lo_i;
                wdata_o    = {4{wdata_i[7:0]}};
                load_o     = uns_i ? {24'h0, lb} : {{24{lb[7]}}, lb};
            end
            SZ_HALF: begin
                err_o      = addr_lo_i[0];
                byte_sel_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                load_o     = uns_i ? {16'h0, lh} : {{16{lh[15]}}, lh};
            end
            SZ_WORD: begin
                err_o      = |addr_lo_i;
                byte_sel_o = 4'b1111;
            end
            default: err_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// Two-requester round-robin front end for a synchronous byte-enabled data memory.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    data_mem_req_if.slave a_io,
    data_mem_req_if.slave b_io,
    data_mem_mem_if.master mem_io
);
    state_e                state_q;
    logic                  prio_b_q, owner_q, we_q, uns_q, err_q;
    size_e                 size_q;
    logic [1:0]            lo_q;
    logic [ADDR_WIDTH-3:0] maddr_q;
    logic                  mwe_q, mre_q;
    logic [3:0]            msel_q;
    logic [31:0]           mwdata_q;
    logic                  rvld_q, rerr_q;
    logic [31:0]           rdata_q;

    logic                  idle, a_gnt, b_gnt, acc;
    logic                  req_we, req_uns;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    size_e                 req_size, al_size;
    logic [1:0]            al_lo;
    logic                  al_err;
    logic [3:0]            al_sel;
    logic [31:0]           al_wdata, al_load;

    assign idle  = (state_q == S_IDLE);
    assign a_gnt = a_io.valid & (~b_io.valid | ~prio_b_q);
    assign b_gnt = b_io.valid & ~a_gnt;
    assign acc   = idle & (a_gnt | b_gnt);

    // Readies are combinational so a waiting requester is taken on the first edge after reset.
    assign a_io.ready = rst_n & idle & a_gnt;
    assign b_io.ready = rst_n & idle & b_gnt;

    assign req_we    = b_gnt ? b_io.we    : a_io.we;
    assign req_uns   = b_gnt ? b_io.uns   : a_io.uns;
    assign req_addr  = b_gnt ? b_io.addr  : a_io.addr;
    assign req_wdata = b_gnt ? b_io.wdata : a_io.wdata;
    assign req_size  = size_e'(b_gnt ? b_io.size : a_io.size);

    // One aligner: decodes the incoming request in IDLE, the captured one while loading.
    assign al_size = idle ? req_size      : size_q;
    assign al_lo   = idle ? req_addr[1:0] : lo_q;

    data_mem_align u_align (
        .size_i    (al_size),
        .addr_lo_i (al_lo),
        .uns_i     (uns_q),
        .wdata_i   (req_wdata),
        .rdata_i   (mem_io.rdata),
        .err_o     (al_err),
        .byte_sel_o(al_sel),
        .wdata_o   (al_wdata),
        .load_o    (al_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            prio_b_q <= 1'b0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= SZ_BYTE;
            lo_q     <= 2'b00;
            maddr_q  <= '0;
            mwe_q    <= 1'b0;
            mre_q    <= 1'b0;
            msel_q   <= 4'b0000;
            mwdata_q <= '0;
            rvld_q   <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (acc) begin
                    state_q  <= S_ISSUE;
                    owner_q  <= b_gnt;
                    prio_b_q <= a_gnt;
                    we_q     <= req_we;
                    uns_q    <= req_uns;
                    size_q   <= req_size;
                    lo_q     <= req_addr[1:0];
                    err_q    <= al_err;
                    mwe_q    <= req_we & ~al_err;
                    mre_q    <= ~req_we & ~al_err;
                    maddr_q  <= al_err ? '0 : req_addr[ADDR_WIDTH-1:2];
                    msel_q   <= al_err ? 4'b0000 : al_sel;
                    mwdata_q <= (req_we & ~al_err) ? al_wdata : '0;
                end
                S_ISSUE: begin
                    state_q  <= S_WAIT;
                    mwe_q    <= 1'b0;
                    mre_q    <= 1'b0;
                    maddr_q  <= '0;
                    msel_q   <= 4'b0000;
                    mwdata_q <= '0;
                end
                S_WAIT: begin
                    state_q <= S_RESP;
                    rvld_q  <= 1'b1;
                    rerr_q  <= err_q;
                    rdata_q <= (we_q | err_q) ? '0 : al_load;
                end
                default: begin
                    state_q <= S_IDLE;
                    rvld_q  <= 1'b0;
                    rerr_q  <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    assign mem_io.addr     = maddr_q;
    assign mem_io.we       = mwe_q;
    assign mem_io.re       = mre_q;
    assign mem_io.byte_sel = msel_q;
    assign mem_io.wdata    = mwdata_q;

    assign a_io.resp_valid = rvld_q & ~owner_q;
    assign a_io.resp_err   = rerr_q & ~owner_q;
    assign a_io.resp_rdata = owner_q ? '0 : rdata_q;
    assign b_io.resp_valid = rvld_q & owner_q;
    assign b_io.resp_err   = rerr_q & owner_q;
    assign b_io.resp_rdata = owner_q ? rdata_q : '0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed-vector bench for data_mem_ctrl with a byte-enabled synchronous memory model.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_req_if #(.ADDR_WIDTH(8)) a_if ();
    data_mem_req_if #(.ADDR_WIDTH(8)) b_if ();
    data_mem_mem_if #(.ADDR_WIDTH(8)) m_if ();

    data_mem_ctrl #(.ADDR_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a_io  (a_if),
        .b_io  (b_if),
        .mem_io(m_if)
    );

    logic [31:0] mem [64] = '{default: 32'h0};

    always @(posedge clk) begin
        if (m_if.we)
            for (int i = 0; i < 4; i++)
                if (m_if.byte_sel[i]) mem[m_if.addr][8*i +: 8] <= m_if.wdata[8*i +: 8];
        if (m_if.re) m_if.rdata <= mem[m_if.addr];
    end

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] mwd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic vec_t mk(input logic we, input logic [7:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata, input logic [3:0] sel,
                                input logic [31:0] mwd, input logic [31:0] rd, input logic err);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
        v.sel = sel; v.mwd = mwd; v.rd = rd; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'h0, act}, {31'h0, exp});
    endtask

    task automatic drive(input bit use_b, input vec_t v, input logic vld);
        if (use_b) begin
            b_if.valid = vld; b_if.we = v.we; b_if.addr = v.addr;
            b_if.size = v.size; b_if.uns = v.uns; b_if.wdata = v.wdata;
        end else begin
            a_if.valid = vld; a_if.we = v.we; a_if.addr = v.addr;
            a_if.size = v.size; a_if.uns = v.uns; a_if.wdata = v.wdata;
        end
    endtask

    // Drop valid and corrupt every request field: captured values must not follow.
    task automatic scramble(input bit use_b, input vec_t v);
        vec_t s;
        s = v;
        s.we = ~v.we; s.addr = ~v.addr; s.size = ~v.size; s.uns = ~v.uns; s.wdata = ~v.wdata;
        drive(use_b, s, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " readies"}, {30'h0, a_if.ready, b_if.ready}, 32'h0);
        chk({tag, " resp_bits"}, {28'h0, a_if.resp_valid, b_if.resp_valid, a_if.resp_err, b_if.resp_err}, 32'h0);
        chk({tag, " resp_rdata"}, a_if.resp_rdata | b_if.resp_rdata, 32'h0);
        chk({tag, " mem_ctl"}, {20'h0, m_if.addr, m_if.we, m_if.re, m_if.byte_sel}, 32'h0);
        chk({tag, " mem_wdata"}, m_if.wdata, 32'h0);
    endtask

    // One transaction: accept at N, check memory side at N+1, response exactly at N+3.
    task automatic xact(input bit use_b, input vec_t v, input string tag);
        int n;
        @(negedge clk);
        drive(use_b, v, 1'b1);
        #1;
        n = 0;
        while (!(use_b ? b_if.ready : a_if.ready) && n < 8) begin
            @(negedge clk); #1; n++;
        end
        chk1({tag, " ready"}, use_b ? b_if.ready : a_if.ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        scramble(use_b, v);
        #1;
        chk1({tag, " issue_we"}, m_if.we, v.we & ~v.err);
        chk1({tag, " issue_re"}, m_if.re, ~v.we & ~v.err);
        chk({tag, " byte_sel"}, {28'h0, m_if.byte_sel}, {28'h0, v.sel});
        chk({tag, " mem_addr"}, {26'h0, m_if.addr}, v.err ? 32'h0 : {26'h0, v.addr[7:2]});
        chk({tag, " mem_wdata"}, m_if.wdata, v.mwd);
        @(negedge clk); #1;
        chk({tag, " wait_quiet"}, {28'h0, m_if.we, m_if.re, a_if.resp_valid, b_if.resp_valid}, 32'h0);
        @(negedge clk); #1;
        chk1({tag, " resp_valid"}, use_b ? b_if.resp_valid : a_if.resp_valid, 1'b1);
        chk1({tag, " other_resp_valid"}, use_b ? a_if.resp_valid : b_if.resp_valid, 1'b0);
        chk({tag, " resp_rdata"}, use_b ? b_if.resp_rdata : a_if.resp_rdata, v.rd);
        chk1({tag, " resp_err"}, use_b ? b_if.resp_err : a_if.resp_err, v.err);
        @(negedge clk); #1;
        chk1({tag, " resp_one_cycle"}, a_if.resp_valid | b_if.resp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    vec_t vt [22];
    vec_t ra, rb, bw, wv, r18;

    initial begin
        logic seen;
        int   n;
        logic g;

        vt[0]  = mk(1, 8'h10, 2'b10, 0, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        vt[1]  = mk(0, 8'h10, 2'b10, 0, 32'h0, 4'hF, 32'h0, 32'hDEADBEEF, 0);
        vt[2]  = mk(1, 8'h13, 2'b00, 0, 32'h12345680, 4'h8, 32'h80808080, 32'h0, 0);
        vt[3]  = mk(0, 8'h13, 2'b00, 0, 32'h0, 4'h8, 32'h0, 32'hFFFFFF80, 0);
        vt[4]  = mk(0, 8'h13, 2'b00, 1, 32'h0, 4'h8, 32'h0, 32'h00000080, 0);
        vt[5]  = mk(0, 8'h10, 2'b00, 1, 32'h0, 4'h1, 32'h0, 32'h000000EF, 0);
        vt[6]  = mk(0, 8'h11, 2'b00, 0, 32'h0, 4'h2, 32'h0, 32'hFFFFFFBE, 0);
        vt[7]  = mk(1, 8'h22, 2'b01, 0, 32'h1234A5C3, 4'hC, 32'hA5C3A5C3, 32'h0, 0);
        vt[8]  = mk(0, 8'h22, 2'b01, 0, 32'h0, 4'hC, 32'h0, 32'hFFFFA5C3, 0);
        vt[9]  = mk(0, 8'h22, 2'b01, 1, 32'h0, 4'hC, 32'h0, 32'h0000A5C3, 0);
        vt[10] = mk(0, 8'h20, 2'b10, 0, 32'h0, 4'hF, 32'h0, 32'hA5C30000, 0);
        vt[11] = mk(0, 8'h12, 2'b01, 0, 32'h0, 4'hC, 32'h0, 32'hFFFF80AD, 0);
        vt[12] = mk(0, 8'h11, 2'b01, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        vt[13] = mk(0, 8'h12, 2'b10, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        vt[14] = mk(0, 8'h10, 2'b11, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        vt[15] = mk(1, 8'h15, 2'b10, 0, 32'hFFFFFFFF, 4'h0, 32'h0, 32'h0, 1);
        vt[16] = mk(1, 8'h13, 2'b01, 0, 32'h0000BEEF, 4'h0, 32'h0, 32'h0, 1);
        vt[17] = mk(0, 8'h14, 2'b10, 0, 32'h0, 4'hF, 32'h0, 32'h0, 0);
        vt[18] = mk(1, 8'h20, 2'b01, 0, 32'h00007E01, 4'h3, 32'h7E017E01, 32'h0, 0);
        vt[19] = mk(0, 8'h20, 2'b10, 0, 32'h0, 4'hF, 32'h0, 32'hA5C37E01, 0);
        vt[20] = mk(0, 8'h20, 2'b01, 0, 32'h0, 4'h3, 32'h0, 32'h00007E01, 0);
        vt[21] = mk(0, 8'h22, 2'b00, 0, 32'h0, 4'h4, 32'h0, 32'hFFFFFFC3, 0);
        bw  = mk(1, 8'h14, 2'b10, 0, 32'h11223344, 4'hF, 32'h11223344, 32'h0, 0);
        ra  = mk(0, 8'h10, 2'b10, 0, 32'h0, 4'hF, 32'h0, 32'h80ADBEEF, 0);
        rb  = mk(0, 8'h14, 2'b10, 0, 32'h0, 4'hF, 32'h0, 32'h11223344, 0);
        wv  = mk(1, 8'h18, 2'b10, 0, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 32'h0, 0);
        r18 = mk(0, 8'h18, 2'b10, 0, 32'h0, 4'hF, 32'h0, 32'h0, 0);

        // Reset with a requester already valid: everything quiet, then ready on release.
        drive(1'b0, ra, 1'b1);
        drive(1'b1, rb, 1'b0);
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("release ready", a_if.ready, 1'b1);
        drive(1'b0, ra, 1'b0);

        for (int i = 0; i < 22; i++) xact(1'b0, vt[i], $sformatf("vec%0d", i));
        xact(1'b1, bw, "b_write");

        // Both requesters held valid: grants must alternate a,b,... starting with a.
        @(negedge clk);
        drive(1'b0, ra, 1'b1);
        drive(1'b1, rb, 1'b1);
        #1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (!(a_if.ready | b_if.ready) && n < 8) begin
                @(negedge clk); #1; n++;
            end
            if (k > 0) chk($sformatf("rr%0d back_to_back", k), n, 0);
            g = b_if.ready;
            chk1($sformatf("rr%0d grant", k), g, k[0]);
            chk1($sformatf("rr%0d one_ready", k), a_if.ready & b_if.ready, 1'b0);
            @(posedge clk);
            @(negedge clk); #1;
            chk1($sformatf("rr%0d busy_ready", k), a_if.ready | b_if.ready, 1'b0);
            @(negedge clk); #1;
            chk1($sformatf("rr%0d early_resp", k), a_if.resp_valid | b_if.resp_valid, 1'b0);
            @(negedge clk); #1;
            chk1($sformatf("rr%0d a_resp", k), a_if.resp_valid, ~g);
            chk1($sformatf("rr%0d b_resp", k), b_if.resp_valid, g);
            chk($sformatf("rr%0d rdata", k), g ? b_if.resp_rdata : a_if.resp_rdata, g ? rb.rd : ra.rd);
            chk($sformatf("rr%0d other_rdata", k), g ? a_if.resp_rdata : b_if.resp_rdata, 32'h0);
            @(negedge clk); #1;
        end
        drive(1'b0, ra, 1'b0);
        drive(1'b1, rb, 1'b0);

        // Reset during ISSUE of a write: mem_we must drop at once and the word stays untouched.
        @(negedge clk);
        drive(1'b0, wv, 1'b1);
        #1;
        chk1("rstw ready", a_if.ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, wv, 1'b0);
        #1;
        chk1("rstw issue_we", m_if.we, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk_zero("rstw");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during WAIT of a read: no response may ever appear.
        @(negedge clk);
        drive(1'b0, ra, 1'b1);
        #1;
        chk1("rstr ready", a_if.ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, ra, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("rstr");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            seen = seen | a_if.resp_valid | b_if.resp_valid;
        end
        chk1("rstr no_resp", seen, 1'b0);

        xact(1'b0, ra, "post_rst");
        xact(1'b0, r18, "rstw_nowrite");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
